ghash_sched: RTL and testbench
==============================

# ghash_sched

Sequencing controller for the 4-slice `split_multiplier` GF(2^128) datapath; implements the GHASH accumulation Y(i) = (Y(i-1) ^ X(i)) · H. It holds the hash key H and accepts 128-bit blocks over a valid/ready handshake. For each block it drives the multiplier's flush / slice / operand protocol, captures the product into the accumulator, and presents the final Y as the tag. It sits between the GCM block buffer and the multiplier, and is the multiplier's only driver.

## Interface
- DATA__WIDTH, 128, block/operand width; fixed at 128.
- SPLIT_WIDTH, 32, key slice width; DATA__WIDTH/SPLIT_WIDTH must equal 4.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- h_i  in  128  hash key H.
- h_load_i  in  1  load H; honoured only in IDLE.
- blk_i  in  128  GHASH input block X(i).
- blk_valid_i  in  1  X(i) valid.
- blk_last_i  in  1  X(i) is the final block of the message.
- blk_ready_o  out  1  block accepted on a cycle where valid & ready.
- tag_o  out  128  final accumulator Y.
- tag_valid_o  out  1  tag_o valid.
- tag_ready_i  in  1  consumer takes the tag.
- busy_o  out  1  a block is in flight, or a tag is pending.
- mul_flush_o  out  1  multiplier flush.
- mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o  out  SPLIT_WIDTH each  H[127:96], H[95:64], H[63:32], H[31:0].
- mul_a_o  out  DATA__WIDTH  multiplier operand.
- mul_i  in  DATA__WIDTH  multiplier product (`mul_o` of `split_multiplier`).

## Operation
- Internal registers:
  - H register plus key_valid flag; both cleared by reset.
  - 128-bit Y accumulator; reset 0.
  - Latched last flag.
- FSM states: IDLE, FLUSH, SA, SB, SC, SD, CAP, TAG.
- IDLE:
  - h_load_i=1 → H <= h_i, key_valid <= 1.
  - blk_ready_o = key_valid & ~h_load_i. A load therefore never coincides with a block acceptance.
  - On valid & ready: latch X and last, go to FLUSH.
- FLUSH: mul_flush_o=1; all other mul outputs 0. Next state SA.
- SA: mul_a_o = Y ^ X, mul_ha_o = H[127:96]; other slices 0.
- SB: drive only mul_hb_o. SC: drive only mul_hc_o. SD: drive only mul_hd_o. mul_a_o is 0 in all three.
- CAP:
  - All mul outputs 0; Y <= mul_i at the end of CAP.
  - Next state is TAG if last was latched, otherwise IDLE.
- TAG:
  - tag_valid_o=1, tag_o=Y.
  - On tag_ready_i: Y <= 0, go to IDLE.
  - tag_o and tag_valid_o hold stable until accepted.
- In every state outside FLUSH..SD, all mul outputs are 0. Exactly one slice output is non-zero per cycle.
- h_load_i outside IDLE is ignored; H is stable for the whole message.
- blk_valid_i while key_valid=0: blk_ready_o stays 0 and the block is held off indefinitely.
- busy_o = (state != IDLE).
- XOR and capture are full 128-bit; no truncation or extension.

## Timing
- All outputs are registered and state-decoded. Exception: blk_ready_o also gates on h_load_i, combinationally.
- Reset values: every output is 0, including blk_ready_o, tag_valid_o and mul_flush_o. State is IDLE; Y, H and key_valid are 0.
- Asynchronous reset mid-message:
  - Immediately returns the block to IDLE, drops busy_o and zeroes the mul outputs.
  - The next block's FLUSH state clears any residue in the multiplier.
- Per-block latency:
  - Acceptance edge (E0) → FLUSH; SA..SD follow on E1..E4; CAP after E5.
  - Y is updated at E6; blk_ready_o re-asserts in the cycle after E6.
  - Minimum block period is 7 cycles.
- Last block: tag_valid_o rises in the cycle after E6. With tag_ready_i already high, IDLE is reached after one TAG cycle.

## Test plan
- Reset then idle:
  - Hold rst=0 for 4 cycles, then release with no loads.
  - Expect all outputs 0 and blk_ready_o=0, including while blk_valid_i=1.
- Single block:
  - Load H=42831ec2217774244b7221b784d0d49c, then send X=b83b533708bf535d0aa6e52980d53b78 with last=1.
  - Expect tag_o=59ed3f2bb1a0aaa07c9f56c6a504647b, tag_valid_o 7 cycles after acceptance.
- Two-block chain:
  - Load H=b83b533708bf535d0aa6e52980d53b78. Send X1 = that same value, then X2 = 0 with last=1.
  - Expect Y1=8a6ff5aca561c0d865805055eb728397 internally and tag_o=c414cb8f1152eb71563a5ca9ddcbddb5.
  - Check the slice protocol per block:
    - flush for exactly 1 cycle;
    - one slice per cycle, in order a, b, c, d;
    - mul_a_o non-zero only in SA.
- Tag backpressure:
  - Hold tag_ready_i=0 for 10 cycles.
  - Expect tag_o and tag_valid_o stable, blk_ready_o=0 and busy_o=1. After acceptance Y is 0.
  - Repeat the single-block message and get the same tag, proving the accumulator was cleared.
- Key load collision:
  - In IDLE, assert h_load_i and blk_valid_i together. Expect blk_ready_o=0 that cycle and H updated.
  - Assert h_load_i during SB. Expect it ignored: the tag still matches the old H.
- Reset mid-block:
  - Drop rst during SC, then restart with the single-block vector.
  - Expect the correct tag 59ed3f2b… and no stale value on tag_o.

Source files
------------

// File: rtl/ghash_sched.sv
`default_nettype none
// ghash_sched: drives the 4-slice split_multiplier to compute Y(i) = (Y(i-1) ^ X(i)) * H
// and presents the final accumulator as the tag.  Rev 1.0
module ghash_sched #(
  parameter int DATA__WIDTH = 128,
  parameter int SPLIT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA__WIDTH-1:0] h_i,
  input  logic                   h_load_i,
  input  logic [DATA__WIDTH-1:0] blk_i,
  input  logic                   blk_valid_i,
  input  logic                   blk_last_i,
  output logic                   blk_ready_o,
  output logic [DATA__WIDTH-1:0] tag_o,
  output logic                   tag_valid_o,
  input  logic                   tag_ready_i,
  output logic                   busy_o,
  output logic                   mul_flush_o,
  output logic [SPLIT_WIDTH-1:0] mul_ha_o,
  output logic [SPLIT_WIDTH-1:0] mul_hb_o,
  output logic [SPLIT_WIDTH-1:0] mul_hc_o,
  output logic [SPLIT_WIDTH-1:0] mul_hd_o,
  output logic [DATA__WIDTH-1:0] mul_a_o,
  input  logic [DATA__WIDTH-1:0] mul_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SA    = 3'd2,
    SB    = 3'd3,
    SC    = 3'd4,
    SD    = 3'd5,
    CAP   = 3'd6,
    TAG   = 3'd7
  } state_t;

  state_t                 state;
  logic [DATA__WIDTH-1:0] h_key;
  logic [DATA__WIDTH-1:0] y_acc;
  logic [DATA__WIDTH-1:0] x_blk;
  logic                   key_valid;
  logic                   last_blk;
  logic                   ready_q;
  logic                   accept;

  // A key load in the same cycle always wins over a block acceptance.
  assign blk_ready_o = ready_q & ~h_load_i;
  assign accept      = blk_valid_i & blk_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      h_key       <= '0;
      y_acc       <= '0;
      x_blk       <= '0;
      key_valid   <= 1'b0;
      last_blk    <= 1'b0;
      ready_q     <= 1'b0;
      tag_o       <= '0;
      tag_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      mul_flush_o <= 1'b0;
      mul_ha_o    <= '0;
      mul_hb_o    <= '0;
      mul_hc_o    <= '0;
      mul_hd_o    <= '0;
      mul_a_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (h_load_i) begin
            h_key     <= h_i;
            key_valid <= 1'b1;
            ready_q   <= 1'b1;
          end else if (accept) begin
            x_blk       <= blk_i;
            last_blk    <= blk_last_i;
            ready_q     <= 1'b0;
            busy_o      <= 1'b1;
            mul_flush_o <= 1'b1;
            state       <= FLUSH;
          end else begin
            ready_q <= key_valid;
          end
        end
        FLUSH: begin
          mul_flush_o <= 1'b0;
          mul_a_o     <= y_acc ^ x_blk;
          mul_ha_o    <= h_key[4*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
          state       <= SA;
        end
        SA: begin
          mul_a_o  <= '0;
          mul_ha_o <= '0;
          mul_hb_o <= h_key[3*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
          state    <= SB;
        end
        SB: begin
          mul_hb_o <= '0;
          mul_hc_o <= h_key[2*SPLIT_WIDTH-1 -: SPLIT_WIDTH];
          state    <= SC;
        end
        SC: begin
          mul_hc_o <= '0;
          mul_hd_o <= h_key[SPLIT_WIDTH-1 -: SPLIT_WIDTH];
          state    <= SD;
        end
        SD: begin
          mul_hd_o <= '0;
          state    <= CAP;
        end
        CAP: begin
          y_acc <= mul_i;
          if (last_blk) begin
            tag_o       <= mul_i;
            tag_valid_o <= 1'b1;
            state       <= TAG;
          end else begin
            busy_o  <= 1'b0;
            ready_q <= key_valid;
            state   <= IDLE;
          end
        end
        TAG: begin
          // The accumulator restarts from zero for the next message.
          if (tag_ready_i) begin
            tag_o       <= '0;
            tag_valid_o <= 1'b0;
            y_acc       <= '0;
            busy_o      <= 1'b0;
            ready_q     <= key_valid;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ghash_sched.sv
`default_nettype none
// tb_ghash_sched: randomized and directed checks of ghash_sched against a GF(2^128)
// reference model; the bench also plays the role of the split_multiplier.
module tb_ghash_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] h_i = '0;
  logic         h_load_i = 1'b0;
  logic [127:0] blk_i = '0;
  logic         blk_valid_i = 1'b0;
  logic         blk_last_i = 1'b0;
  logic         blk_ready_o;
  logic [127:0] tag_o;
  logic         tag_valid_o;
  logic         tag_ready_i = 1'b1;
  logic         busy_o;
  logic         mul_flush_o;
  logic [31:0]  mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o;
  logic [127:0] mul_a_o;
  logic [127:0] mul_i = '0;

  int vectors = 0;
  int errors  = 0;

  logic [127:0] model_h = '0;
  logic [127:0] model_y = '0;
  logic [127:0] sa_a    = '0;
  logic [127:0] op_a    = '0;
  logic [127:0] h_cap   = '0;
  int           phase   = 0;

  localparam logic [127:0] H1   = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] X1   = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] T1   = 128'h59ed3f2bb1a0aaa07c9f56c6a504647b;
  localparam logic [127:0] Y1_2 = 128'h8a6ff5aca561c0d865805055eb728397;
  localparam logic [127:0] T2   = 128'hc414cb8f1152eb71563a5ca9ddcbddb5;

  ghash_sched #(.DATA__WIDTH(128), .SPLIT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .h_i(h_i), .h_load_i(h_load_i),
    .blk_i(blk_i), .blk_valid_i(blk_valid_i), .blk_last_i(blk_last_i),
    .blk_ready_o(blk_ready_o), .tag_o(tag_o), .tag_valid_o(tag_valid_o),
    .tag_ready_i(tag_ready_i), .busy_o(busy_o), .mul_flush_o(mul_flush_o),
    .mul_ha_o(mul_ha_o), .mul_hb_o(mul_hb_o), .mul_hc_o(mul_hc_o), .mul_hd_o(mul_hd_o),
    .mul_a_o(mul_a_o), .mul_i(mul_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // GCM bit-reflected multiply in GF(2^128), x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiplier stand-in and slice-protocol monitor.
  always @(negedge clk) begin
    if (!rst) begin
      phase = 0;
    end else begin
      case (phase)
        0: begin
          check("idle_a", mul_a_o, '0);
          check("idle_slices", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, '0);
          if (mul_flush_o) begin
            mul_i = rand128();
            phase = 1;
          end
        end
        1: begin
          check("flush_len", mul_flush_o, 1'b0);
          check("sa_slices", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, {model_h[127:96], 96'h0});
          op_a  = mul_a_o;
          sa_a  = mul_a_o;
          h_cap[127:96] = mul_ha_o;
          phase = 2;
        end
        2, 3, 4: begin
          check("sx_flush", mul_flush_o, 1'b0);
          check("sx_a_zero", mul_a_o, '0);
          if (phase == 2) begin
            check("sb_slices", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, {32'h0, model_h[95:64], 64'h0});
            h_cap[95:64] = mul_hb_o;
          end else if (phase == 3) begin
            check("sc_slices", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, {64'h0, model_h[63:32], 32'h0});
            h_cap[63:32] = mul_hc_o;
          end else begin
            check("sd_slices", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, {96'h0, model_h[31:0]});
            h_cap[31:0] = mul_hd_o;
            mul_i = gf_mul(op_a, h_cap);
          end
          phase = phase + 1;
        end
        default: begin
          check("cap_flush", mul_flush_o, 1'b0);
          check("cap_a", mul_a_o, '0);
          check("cap_slices", {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, '0);
          phase = 0;
        end
      endcase
    end
  end

  task automatic check_quiet(input string pre);
    check({pre, "_tag"}, tag_o, '0);
    check({pre, "_tag_valid"}, tag_valid_o, 1'b0);
    check({pre, "_busy"}, busy_o, 1'b0);
    check({pre, "_flush"}, mul_flush_o, 1'b0);
    check({pre, "_ready"}, blk_ready_o, 1'b0);
    check({pre, "_a"}, mul_a_o, '0);
    check({pre, "_slices"}, {mul_ha_o, mul_hb_o, mul_hc_o, mul_hd_o}, '0);
  endtask

  task automatic load_key(input logic [127:0] h);
    @(negedge clk);
    h_i = h;
    h_load_i = 1'b1;
    @(negedge clk);
    h_load_i = 1'b0;
    model_h = h;
  endtask

  // Returns at the falling edge of the FLUSH cycle.
  task automatic send_block(input logic [127:0] x, input logic last);
    int n;
    @(negedge clk);
    blk_i = x;
    blk_last_i = last;
    blk_valid_i = 1'b1;
    n = 0;
    #1;
    while (!blk_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_timeout", n < 50, 1'b1);
    @(posedge clk);
    model_y = gf_mul(model_y ^ x, model_h);
    @(negedge clk);
    blk_valid_i = 1'b0;
  endtask

  task automatic finish_msg(input int stall, input int exp_lat, output logic [127:0] got);
    int lat;
    logic [127:0] t;
    tag_ready_i = (stall == 0);
    lat = 1;
    while (!tag_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("tag_timeout", lat < 40, 1'b1);
    if (exp_lat != 0) check("tag_latency", lat, exp_lat);
    check("tag_value", tag_o, model_y);
    t = tag_o;
    got = tag_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("tag_hold", tag_o, t);
      check("tag_hold_valid", tag_valid_o, 1'b1);
      check("tag_hold_busy", busy_o, 1'b1);
      check("tag_hold_ready", blk_ready_o, 1'b0);
    end
    tag_ready_i = 1'b1;
    @(negedge clk);
    check("tag_drop", tag_valid_o, 1'b0);
    check("tag_idle", busy_o, 1'b0);
    check("tag_cleared", tag_o, '0);
    model_y = '0;
  endtask

  initial begin
    logic [127:0] t;
    logic [127:0] hb;
    int nb;

    // Reset, then idle with no key: blocks must be held off.
    blk_valid_i = 1'b1;
    blk_i = X1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_quiet("rst");
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_quiet("nokey");
    end
    blk_valid_i = 1'b0;

    // Single block with the reference vector.
    load_key(H1);
    send_block(X1, 1'b1);
    finish_msg(0, 7, t);
    check("single_tag", t, T1);

    // Two-block chain with block-rate and intermediate-Y checks.
    load_key(X1);
    send_block(X1, 1'b0);
    check("ready_gap_1", blk_ready_o, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk);
      check("ready_gap", blk_ready_o, (i == 7) ? 1'b1 : 1'b0);
    end
    send_block('0, 1'b1);
    finish_msg(0, 7, t);
    check("chain_y1", sa_a, Y1_2);
    check("chain_tag", t, T2);

    // Tag backpressure, then the same message again.
    load_key(H1);
    send_block(X1, 1'b1);
    finish_msg(10, 7, t);
    check("bp_tag", t, T1);
    send_block(X1, 1'b1);
    finish_msg(0, 7, t);
    check("bp_repeat_tag", t, T1);

    // Key load colliding with a valid block in IDLE.
    hb = rand128();
    @(negedge clk);
    h_i = hb;
    h_load_i = 1'b1;
    blk_i = X1;
    blk_last_i = 1'b1;
    blk_valid_i = 1'b1;
    #1 check("collide_ready", blk_ready_o, 1'b0);
    @(negedge clk);
    h_load_i = 1'b0;
    blk_valid_i = 1'b0;
    model_h = hb;
    send_block(X1, 1'b1);
    finish_msg(0, 7, t);
    check("collide_tag", t, gf_mul(X1, hb));

    // Key load during SB is ignored.
    load_key(H1);
    send_block(X1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    h_i = rand128();
    h_load_i = 1'b1;
    @(negedge clk);
    h_load_i = 1'b0;
    finish_msg(0, 0, t);
    check("sb_load_tag", t, T1);

    // Asynchronous reset during SC, then restart.
    send_block(X1, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_quiet("midrst");
    model_y = '0;
    model_h = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    load_key(H1);
    send_block(X1, 1'b1);
    finish_msg(0, 7, t);
    check("midrst_tag", t, T1);

    // Randomized messages.
    for (int m = 0; m < 12; m++) begin
      nb = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) load_key(rand128());
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_block(rand128(), b == nb - 1);
      end
      finish_msg($urandom_range(0, 3), 7, t);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
